// File: rtl/mlp_pkg.sv
// Shared constants and the activation function for the MLP datapath.
// act() shifts the accumulator, then applies ReLU and saturates to the signed data range.
package mlp_pkg;
  localparam int DataW    = 8;
  localparam int AccW     = 2 * DataW + 4;
  localparam int FracBits = 0;
  localparam int Dim      = 16;
  localparam int LayerNum = 8;
  localparam int WAddrW   = 11;
  localparam int XAddrW   = 8;
  localparam int WDepth   = LayerNum * Dim * Dim;
  localparam int XDepth   = 1 << XAddrW;

  localparam logic signed [AccW-1:0] ActMax = AccW'((1 << (DataW - 1)) - 1);

  function automatic logic [DataW-1:0] act(input logic signed [AccW-1:0] a);
    logic signed [AccW-1:0] s;
    s = a >>> FracBits;
    if (s[AccW-1])
      act = '0;
    else if (s > ActMax)
      act = ActMax[DataW-1:0];
    else
      act = s[DataW-1:0];
  endfunction
endpackage

// File: rtl/mlp_sram.sv
// Single-port RAM with a registered read port; a same-cycle read of the address
// being written returns the old word. Only the read register is reset, never the array.
module mlp_sram #(
  parameter int Depth = 256,
  parameter int Width = 8,
  parameter int AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             re_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);
  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
  end

  // Read data holds its value until the next read strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      r_rdata <= '0;
    else if (re_i)
      r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;
endmodule

// File: rtl/mlp_datapath.sv
// Storage and arithmetic half of the MLP engine: weight RAM, ping-pong activation
// banks, signed MAC accumulator and activated write-back, driven by the control FSM.
module mlp_datapath
  import mlp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DataW-1:0]  ext_data_i,
  input  logic              w_ren_i,
  input  logic              w_wen_i,
  input  logic [WAddrW-1:0] w_addr_i,
  input  logic              x_ren_i,
  input  logic              x_wen_i,
  input  logic              x_sel_i,
  input  logic [XAddrW-1:0] x_addr_i,
  input  logic              wb_i,
  output logic [DataW-1:0]  result_data_o
);
  logic signed [AccW-1:0]    r_acc;
  logic                      r_mac_q;
  logic                      r_rd_sel;

  logic [DataW-1:0]          w_w_rdata;
  logic [DataW-1:0]          w_x0_rdata;
  logic [DataW-1:0]          w_x1_rdata;
  logic [DataW-1:0]          w_x_rdata;
  logic                      w_wr_bank;
  logic                      w_x_we;
  logic [DataW-1:0]          w_x_wdata;
  logic signed [2*DataW-1:0] w_prod;
  logic signed [AccW-1:0]    w_prod_ext;

  // Write-back targets the bank the next layer reads; loads target the selected bank.
  assign w_wr_bank = wb_i ? ~x_sel_i : x_sel_i;
  assign w_x_we    = x_wen_i | wb_i;
  assign w_x_wdata = wb_i ? act(r_acc) : ext_data_i;

  mlp_sram #(.Depth(WDepth), .Width(DataW)) u_w_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (w_ren_i),
    .we_i    (w_wen_i),
    .addr_i  (w_addr_i),
    .wdata_i (ext_data_i),
    .rdata_o (w_w_rdata)
  );

  mlp_sram #(.Depth(XDepth), .Width(DataW)) u_x0_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (x_ren_i & ~x_sel_i),
    .we_i    (w_x_we & ~w_wr_bank),
    .addr_i  (x_addr_i),
    .wdata_i (w_x_wdata),
    .rdata_o (w_x0_rdata)
  );

  mlp_sram #(.Depth(XDepth), .Width(DataW)) u_x1_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (x_ren_i & x_sel_i),
    .we_i    (w_x_we & w_wr_bank),
    .addr_i  (x_addr_i),
    .wdata_i (w_x_wdata),
    .rdata_o (w_x1_rdata)
  );

  assign w_x_rdata     = r_rd_sel ? w_x1_rdata : w_x0_rdata;
  assign result_data_o = w_x_rdata;

  assign w_prod     = $signed(w_x_rdata) * $signed(w_w_rdata);
  assign w_prod_ext = {{(AccW - 2*DataW){w_prod[2*DataW-1]}}, w_prod};

  // Write-back clear takes priority over a (never expected) coincident MAC.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc    <= '0;
      r_mac_q  <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_mac_q <= x_ren_i & w_ren_i;
      if (x_ren_i) r_rd_sel <= x_sel_i;
      if (wb_i)
        r_acc <= '0;
      else if (r_mac_q)
        r_acc <= r_acc + w_prod_ext;
    end
  end
endmodule
